// File: rtl/life_pkg.sv
// Shared definitions for the Game of Life generation sequencer.
//   DEFAULT_COLS  : cells per row (row word width)
//   DEFAULT_ROWS  : rows in the grid
//   DEFAULT_ROW_W : row address width, clog2(DEFAULT_ROWS)
//   state_t       : sequencer FSM states
package life_pkg;

    localparam int DEFAULT_COLS  = 20;
    localparam int DEFAULT_ROWS  = 16;
    localparam int DEFAULT_ROW_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        FILL0,
        FILL1,
        FILL2,
        ROW,
        WAIT,
        COMMIT
    } state_t;

endpackage

// File: rtl/life_row_rule.sv
// Combinational B3/S23 rule for one full row of cells.
//   prev_row : row above the row being updated
//   cur_row  : row being updated
//   next_row : row below the row being updated
//   new_row  : next state of cur_row, new_row[i] = column i
// WRAP != 0 joins column 0 and column COLS-1; otherwise the
// columns beyond either edge are treated as dead.
module life_row_rule #(
    parameter int COLS = 20,
    parameter int WRAP = 0
) (
    input  logic [COLS-1:0] prev_row,
    input  logic [COLS-1:0] cur_row,
    input  logic [COLS-1:0] next_row,
    output logic [COLS-1:0] new_row
);

    localparam logic WRAP_EN = (WRAP != 0);

    logic [COLS+1:0] prev_ext;
    logic [COLS+1:0] cur_ext;
    logic [COLS+1:0] next_ext;

    // Each row is padded with one ghost column on both sides so that
    // column i of the original row sits at bit i+1 of the padded row.
    assign prev_ext = {WRAP_EN & prev_row[0], prev_row, WRAP_EN & prev_row[COLS-1]};
    assign cur_ext  = {WRAP_EN & cur_row[0],  cur_row,  WRAP_EN & cur_row[COLS-1]};
    assign next_ext = {WRAP_EN & next_row[0], next_row, WRAP_EN & next_row[COLS-1]};

    for (genvar i = 0; i < COLS; i++) begin : g_cell
        logic [3:0] count;

        // Eight neighbours; the cell itself (cur_ext[i+1]) is excluded.
        assign count = 4'(prev_ext[i]) + 4'(prev_ext[i+1]) + 4'(prev_ext[i+2])
                     + 4'(cur_ext[i])                      + 4'(cur_ext[i+2])
                     + 4'(next_ext[i]) + 4'(next_ext[i+1]) + 4'(next_ext[i+2]);

        assign new_row[i] = (count == 4'd3) || (cur_row[i] && (count == 4'd2));
    end

endmodule

// File: rtl/life_gen_sequencer.sv
// Runs one Game of Life generation per video frame.
//   clk, clr           : clock and synchronous active-low reset
//   vsync              : active-low VGA vsync; the rising edge starts a
//                        generation, the falling edge commits it
//   run, step          : free-run level / single-generation request pulse
//   rd_en/rd_row       : read port of the current-state row store
//   rd_data            : current-state row, valid one cycle after rd_en
//   wr_en/wr_row/wr_data : write port of the next-state row store
//   commit             : one-cycle pulse to swap the next-state store in
//   busy               : high from generation start until commit
//   gen_count          : number of committed generations (wraps)
module life_gen_sequencer
    import life_pkg::*;
#(
    parameter int COLS  = DEFAULT_COLS,
    parameter int ROWS  = DEFAULT_ROWS,
    parameter int ROW_W = DEFAULT_ROW_W,
    parameter int WRAP  = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             vsync,
    input  logic             run,
    input  logic             step,
    output logic             rd_en,
    output logic [ROW_W-1:0] rd_row,
    input  logic [COLS-1:0]  rd_data,
    output logic             wr_en,
    output logic [ROW_W-1:0] wr_row,
    output logic [COLS-1:0]  wr_data,
    output logic             commit,
    output logic             busy,
    output logic [15:0]      gen_count
);

    localparam logic             WRAP_EN  = (WRAP != 0);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    state_t          state;
    logic            vsync_d;
    logic            rise;
    logic            fall;
    logic            start;
    logic            step_pending;
    logic [COLS-1:0] prev_row;
    logic [COLS-1:0] cur_row;
    logic [COLS-1:0] next_row;
    logic [COLS-1:0] rule_row;
    logic            next_valid;
    int              ahead;
    logic [ROW_W-1:0] ahead_row;
    logic            ahead_ok;

    assign rise  = ~vsync_d & vsync;
    assign fall  = vsync_d & ~vsync;
    assign start = (state == IDLE) && rise && (run || step_pending);

    // wr_row doubles as the row counter r. While processing row r the
    // read for row r+2 is set up for the following cycle, i.e. r+3 of
    // the row the counter is about to advance from.
    assign ahead     = int'(wr_row) + 3;
    assign ahead_row = ROW_W'(ahead % ROWS);
    assign ahead_ok  = WRAP_EN || (ahead < ROWS);

    // Without wrap there is no row below the last one: it reads as dead.
    assign next_valid = (state == ROW) && (WRAP_EN || (wr_row != LAST_ROW));
    assign next_row   = next_valid ? rd_data : '0;

    life_row_rule #(
        .COLS (COLS),
        .WRAP (WRAP)
    ) u_rule (
        .prev_row (prev_row),
        .cur_row  (cur_row),
        .next_row (next_row),
        .new_row  (rule_row)
    );

    // The result row depends on rd_data arriving in the same cycle, so
    // it is presented combinationally and qualified by the write strobe.
    assign wr_data = wr_en ? rule_row : '0;

    always_ff @(posedge clk) begin
        if (!clr) begin
            state        <= IDLE;
            rd_en        <= 1'b0;
            rd_row       <= '0;
            wr_en        <= 1'b0;
            wr_row       <= '0;
            commit       <= 1'b0;
            busy         <= 1'b0;
            gen_count    <= '0;
            step_pending <= 1'b0;
            vsync_d      <= 1'b1;
            prev_row     <= '0;
            cur_row      <= '0;
        end else begin
            vsync_d <= vsync;

            // A step taken on the start cycle itself stays queued so that
            // every accepted pulse yields its own generation.
            if (step && !run) begin
                step_pending <= 1'b1;
            end else if (start) begin
                step_pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= FILL0;
                        busy   <= 1'b1;
                        rd_en  <= WRAP_EN;
                        rd_row <= LAST_ROW;
                    end
                end
                FILL0: begin
                    if (!WRAP_EN) begin
                        prev_row <= '0;
                    end
                    state  <= FILL1;
                    rd_en  <= 1'b1;
                    rd_row <= '0;
                end
                FILL1: begin
                    if (WRAP_EN) begin
                        prev_row <= rd_data;
                    end
                    state  <= FILL2;
                    rd_en  <= 1'b1;
                    rd_row <= ROW_W'(1);
                end
                FILL2: begin
                    cur_row <= rd_data;
                    state   <= ROW;
                    wr_en   <= 1'b1;
                    wr_row  <= '0;
                    rd_en   <= WRAP_EN || (ROWS > 2);
                    rd_row  <= ROW_W'(2 % ROWS);
                end
                ROW: begin
                    prev_row <= cur_row;
                    cur_row  <= next_row;
                    if (wr_row == LAST_ROW) begin
                        state <= WAIT;
                        wr_en <= 1'b0;
                        rd_en <= 1'b0;
                    end else begin
                        wr_row <= wr_row + ROW_W'(1);
                        rd_row <= ahead_row;
                        rd_en  <= ahead_ok;
                    end
                end
                WAIT: begin
                    if (fall) begin
                        state     <= COMMIT;
                        commit    <= 1'b1;
                        gen_count <= gen_count + 16'd1;
                    end
                end
                COMMIT: begin
                    state  <= IDLE;
                    commit <= 1'b0;
                    busy   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Bench for life_gen_sequencer: one instance with dead edges and one
// with toroidal edges share all control inputs, each with its own
// current/next row store model. Results are checked against a
// cell-by-cell Game of Life model of the whole grid.
module tb_life_gen_sequencer;

    localparam int COLS  = 20;
    localparam int ROWS  = 16;
    localparam int ROW_W = 4;

    typedef logic [ROWS-1:0][COLS-1:0] grid_t;

    logic clk   = 1'b0;
    logic clr   = 1'b0;
    logic vsync = 1'b0;
    logic run   = 1'b0;
    logic step  = 1'b0;

    logic             rd_en_v   [2];
    logic [ROW_W-1:0] rd_row_v  [2];
    logic [COLS-1:0]  rd_data_v [2];
    logic             wr_en_v   [2];
    logic [ROW_W-1:0] wr_row_v  [2];
    logic [COLS-1:0]  wr_data_v [2];
    logic             commit_v  [2];
    logic             busy_v    [2];
    logic [15:0]      gen_v     [2];

    grid_t cur_mem  [2];
    grid_t nxt_mem  [2];
    grid_t load_pat [2];
    logic  load_req = 1'b0;

    grid_t exp_grid [2];
    int    exp_gen  [2];

    int vectors     = 0;
    int miscompares = 0;

    // Per-frame observations, index 0 = dead edges, 1 = wrapped
    int   wr_cnt [2];
    int   wr_first [2];
    int   wr_last [2];
    int   rd_cnt [2];
    int   cm_cnt [2];
    int   cm_at [2];
    int   busy_first [2];
    logic busy_end [2];
    logic pc_busy [2];
    logic pc_wr [2];
    logic pc_commit [2];
    logic [15:0] pc_gen [2];

    always #5 clk = ~clk;

    life_gen_sequencer #(.COLS(COLS), .ROWS(ROWS), .ROW_W(ROW_W), .WRAP(0)) dut_dead (
        .clk(clk), .clr(clr), .vsync(vsync), .run(run), .step(step),
        .rd_en(rd_en_v[0]), .rd_row(rd_row_v[0]), .rd_data(rd_data_v[0]),
        .wr_en(wr_en_v[0]), .wr_row(wr_row_v[0]), .wr_data(wr_data_v[0]),
        .commit(commit_v[0]), .busy(busy_v[0]), .gen_count(gen_v[0])
    );

    life_gen_sequencer #(.COLS(COLS), .ROWS(ROWS), .ROW_W(ROW_W), .WRAP(1)) dut_wrap (
        .clk(clk), .clr(clr), .vsync(vsync), .run(run), .step(step),
        .rd_en(rd_en_v[1]), .rd_row(rd_row_v[1]), .rd_data(rd_data_v[1]),
        .wr_en(wr_en_v[1]), .wr_row(wr_row_v[1]), .wr_data(wr_data_v[1]),
        .commit(commit_v[1]), .busy(busy_v[1]), .gen_count(gen_v[1])
    );

    // Row stores: 1-cycle read latency, commit copies next into current.
    always @(posedge clk) begin
        for (int w = 0; w < 2; w++) begin
            if (rd_en_v[w]) rd_data_v[w] <= cur_mem[w][rd_row_v[w]];
            if (wr_en_v[w]) nxt_mem[w][wr_row_v[w]] <= wr_data_v[w];
            if (load_req) cur_mem[w] <= load_pat[w];
            else if (commit_v[w]) cur_mem[w] <= nxt_mem[w];
        end
    end

    function automatic grid_t life_step(input grid_t g, input bit wrap);
        grid_t n;
        n = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                int cnt;
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr;
                        int cc;
                        rr = r + dr;
                        cc = c + dc;
                        if (dr == 0 && dc == 0) continue;
                        if (wrap) begin
                            rr = (rr + ROWS) % ROWS;
                            cc = (cc + COLS) % COLS;
                        end else if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) begin
                            continue;
                        end
                        if (g[rr][cc]) cnt++;
                    end
                end
                n[r][c] = (cnt == 3) || (g[r][c] && cnt == 2);
            end
        end
        return n;
    endfunction

    // Glider heading down-right, bounding box top-left at (r0, c0)
    function automatic grid_t mk_glider(input int r0, input int c0);
        grid_t g;
        g = '0;
        g[r0 % ROWS][(c0 + 1) % COLS]             = 1'b1;
        g[(r0 + 1) % ROWS][(c0 + 2) % COLS]       = 1'b1;
        g[(r0 + 2) % ROWS][c0 % COLS]             = 1'b1;
        g[(r0 + 2) % ROWS][(c0 + 1) % COLS]       = 1'b1;
        g[(r0 + 2) % ROWS][(c0 + 2) % COLS]       = 1'b1;
        return g;
    endfunction

    function automatic grid_t rand_grid();
        grid_t g;
        for (int r = 0; r < ROWS; r++) g[r] = COLS'($urandom() & $urandom());
        return g;
    endfunction

    task automatic checkOutput(input string tag, input int w,
                               input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s[%0d]: observed %0d, expected %0d", tag, w, obs, expv);
        end
    endtask

    task automatic checkGrid(input string tag, input int w, input grid_t obs, input grid_t expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s[%0d]: observed %h, expected %h", tag, w, obs, expv);
        end
    endtask

    task automatic doReset();
        clr   = 1'b0;
        vsync = 1'b0;
        step  = 1'b0;
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            checkOutput("rst_rd_en", w, 32'(rd_en_v[w]), 0);
            checkOutput("rst_rd_row", w, 32'(rd_row_v[w]), 0);
            checkOutput("rst_wr_en", w, 32'(wr_en_v[w]), 0);
            checkOutput("rst_wr_row", w, 32'(wr_row_v[w]), 0);
            checkOutput("rst_wr_data", w, 32'(wr_data_v[w]), 0);
            checkOutput("rst_commit", w, 32'(commit_v[w]), 0);
            checkOutput("rst_busy", w, 32'(busy_v[w]), 0);
            checkOutput("rst_gen", w, 32'(gen_v[w]), 0);
            exp_gen[w] = 0;
        end
        @(negedge clk);
        clr = 1'b1;
        // Let vsync_d settle low so the next frame sees a rising edge
        @(negedge clk);
    endtask

    task automatic loadGrid(input grid_t g0, input grid_t g1);
        load_pat[0] = g0;
        load_pat[1] = g1;
        exp_grid[0] = g0;
        exp_grid[1] = g1;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // One frame: vsync high for cycles 0..high_len-1 then low for 4
    // cycles. Outputs of cycle k are sampled at the negedge inside it.
    task automatic applyStimulus(input int high_len, input int step_at, input int clr_at);
        int total;
        total = high_len + 4;
        for (int w = 0; w < 2; w++) begin
            wr_cnt[w] = 0; wr_first[w] = -1; wr_last[w] = -1; rd_cnt[w] = 0;
            cm_cnt[w] = 0; cm_at[w] = -1; busy_first[w] = -1; busy_end[w] = 1'bx;
            pc_busy[w] = 1'b1; pc_wr[w] = 1'b1; pc_commit[w] = 1'b1; pc_gen[w] = '1;
        end
        vsync = 1'b1;
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            for (int w = 0; w < 2; w++) begin
                if (wr_en_v[w]) begin
                    wr_cnt[w]++;
                    if (wr_first[w] < 0) wr_first[w] = k;
                    wr_last[w] = k;
                end
                if (rd_en_v[w]) rd_cnt[w]++;
                if (commit_v[w]) begin
                    cm_cnt[w]++;
                    cm_at[w] = k;
                end
                if (busy_v[w] && busy_first[w] < 0) busy_first[w] = k;
                if (k == total) busy_end[w] = busy_v[w];
                if (k == clr_at + 1) begin
                    pc_busy[w]   = busy_v[w];
                    pc_wr[w]     = wr_en_v[w];
                    pc_commit[w] = commit_v[w];
                    pc_gen[w]    = gen_v[w];
                end
            end
            step  = (k == step_at);
            clr   = (k != clr_at);
            vsync = (k < high_len);
        end
    endtask

    // Checks a normal frame: either one complete generation or nothing.
    task automatic checkFrame(input int high_len, input bit active);
        for (int w = 0; w < 2; w++) begin
            if (active) begin
                exp_grid[w] = life_step(exp_grid[w], w == 1);
                exp_gen[w]  = (exp_gen[w] + 1) & 16'hFFFF;
                checkOutput("wr_count", w, wr_cnt[w], ROWS);
                checkOutput("wr_first", w, wr_first[w], 4);
                checkOutput("wr_last", w, wr_last[w], 4 + ROWS - 1);
                checkOutput("rd_count", w, rd_cnt[w], (w == 1) ? ROWS + 3 : ROWS);
                checkOutput("commit_count", w, cm_cnt[w], 1);
                checkOutput("commit_cycle", w, cm_at[w], high_len + 1);
                checkOutput("busy_first", w, busy_first[w], 1);
                checkOutput("busy_end", w, 32'(busy_end[w]), 0);
            end else begin
                checkOutput("idle_wr_count", w, wr_cnt[w], 0);
                checkOutput("idle_rd_count", w, rd_cnt[w], 0);
                checkOutput("idle_commit_count", w, cm_cnt[w], 0);
            end
            checkOutput("gen_count", w, 32'(gen_v[w]), exp_gen[w]);
            checkGrid("grid", w, cur_mem[w], exp_grid[w]);
        end
    endtask

    initial begin
        grid_t g;
        grid_t blink_exp;
        int    h;
        int    wr_short [2];

        $display("[TB] start");
        doReset();

        // Blinker in the middle of the grid
        g = '0;
        g[5][11:9] = 3'b111;
        loadGrid(g, g);
        run = 1'b1;
        applyStimulus(24, -1, -1);
        checkFrame(24, 1'b1);
        blink_exp = '0;
        blink_exp[4][10] = 1'b1;
        blink_exp[5][10] = 1'b1;
        blink_exp[6][10] = 1'b1;
        for (int w = 0; w < 2; w++) checkGrid("blinker_shape", w, cur_mem[w], blink_exp);

        // Still-life block over three frames
        doReset();
        g = '0;
        g[7][4:3] = 2'b11;
        g[8][4:3] = 2'b11;
        loadGrid(g, g);
        for (int f = 0; f < 3; f++) begin
            applyStimulus(24, -1, -1);
            checkFrame(24, 1'b1);
            for (int w = 0; w < 2; w++) checkGrid("block_still", w, cur_mem[w], g);
        end
        for (int w = 0; w < 2; w++) checkOutput("block_gen", w, 32'(gen_v[w]), 3);

        // Glider straddling the bottom-right corner
        doReset();
        loadGrid(mk_glider(14, 18), mk_glider(14, 18));
        for (int f = 0; f < 4; f++) begin
            applyStimulus(24, -1, -1);
            checkFrame(24, 1'b1);
        end
        checkGrid("glider_shift", 1, cur_mem[1], mk_glider(15, 19));

        // Random soups with random frame lengths
        for (int i = 0; i < 6; i++) begin
            loadGrid(rand_grid(), rand_grid());
            h = 20 + int'($urandom_range(0, 10));
            applyStimulus(h, -1, -1);
            checkFrame(h, 1'b1);
        end

        // Stopped: nothing happens without a step
        loadGrid(rand_grid(), rand_grid());
        run = 1'b0;
        for (int f = 0; f < 3; f++) begin
            applyStimulus(24, -1, -1);
            checkFrame(24, 1'b0);
        end

        // One step, plus another step taken while that generation is busy
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        applyStimulus(24, 8, -1);
        checkFrame(24, 1'b1);
        applyStimulus(24, -1, -1);
        checkFrame(24, 1'b1);
        applyStimulus(24, -1, -1);
        checkFrame(24, 1'b0);

        // A step while running is not remembered
        run = 1'b1;
        applyStimulus(24, 2, -1);
        checkFrame(24, 1'b1);
        run = 1'b0;
        applyStimulus(24, -1, -1);
        checkFrame(24, 1'b0);

        // Short frame: the fall lands mid-generation, commit waits a frame
        run = 1'b1;
        loadGrid(rand_grid(), rand_grid());
        applyStimulus(10, -1, -1);
        for (int w = 0; w < 2; w++) begin
            wr_short[w] = wr_cnt[w];
            checkOutput("short_commit_count", w, cm_cnt[w], 0);
            checkOutput("short_busy_end", w, 32'(busy_end[w]), 1);
        end
        run = 1'b0;
        applyStimulus(24, -1, -1);
        for (int w = 0; w < 2; w++) begin
            exp_grid[w] = life_step(exp_grid[w], w == 1);
            exp_gen[w]  = exp_gen[w] + 1;
            checkOutput("short_wr_total", w, wr_short[w] + wr_cnt[w], ROWS);
            checkOutput("late_commit_count", w, cm_cnt[w], 1);
            checkOutput("late_commit_cycle", w, cm_at[w], 25);
            checkOutput("late_busy_end", w, 32'(busy_end[w]), 0);
            checkOutput("late_gen", w, 32'(gen_v[w]), exp_gen[w]);
            checkGrid("late_grid", w, cur_mem[w], exp_grid[w]);
        end

        // Reset in the middle of the row pass, then resume
        run = 1'b1;
        applyStimulus(24, -1, 8);
        for (int w = 0; w < 2; w++) begin
            checkOutput("midrst_busy", w, 32'(pc_busy[w]), 0);
            checkOutput("midrst_wr_en", w, 32'(pc_wr[w]), 0);
            checkOutput("midrst_commit", w, 32'(pc_commit[w]), 0);
            checkOutput("midrst_gen", w, 32'(pc_gen[w]), 0);
            checkOutput("midrst_commit_count", w, cm_cnt[w], 0);
            exp_gen[w] = 0;
        end
        applyStimulus(24, -1, -1);
        checkFrame(24, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
